morse_sequence_player: RTL and testbench

//  Consumer end of the sequence-separator interface. Accepts one {FirstSeq, SecSeq} pair of 10-bit

---
 rtl/morse_sequence_player.sv | 183 ++++++++++++++++++
 tb/tb_morse_sequence_player.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/morse_sequence_player.sv
// Plays a captured pair of 10-bit encoded Morse sequences as a timed on/off keying signal.
// Symbols are 2-bit pairs, MSB first: 00 dot, 01 dash, 10 space, 11 empty.
module morse_sequence_player #(
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       Clk,
  input  logic       Resetbar,
  input  logic [9:0] FirstSeq,
  input  logic [9:0] SecSeq,
  input  logic       SeqValid,
  output logic       SeqReady,
  output logic       Busy,
  output logic       MorseOut,
  output logic       Done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StMark,
    StElemGap,
    StGap,
    StDone
  } stateT;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(UNIT_CYCLES - 1);

  stateT            stateQ, stateD;
  logic [9:0]       firstQ, firstD;
  logic [9:0]       secQ, secD;
  logic             selQ, selD;
  logic [2:0]       idxQ, idxD;
  logic             lfQ, lfD;
  logic [2:0]       unitsQ, unitsD;
  logic [CNT_W-1:0] cntQ, cntD;

  logic             morseQ, morseD;
  logic             doneQ, doneD;
  logic             readyQ, readyD;

  logic [9:0]       curSeq;
  logic [1:0]       sym;
  logic             unitEnd;
  logic             endSeq;

  // State register and datapath registers
  always_ff @(posedge Clk or negedge Resetbar) begin
    if (!Resetbar) begin
      stateQ <= StIdle;
      firstQ <= '0;
      secQ   <= '0;
      selQ   <= 1'b0;
      idxQ   <= '0;
      lfQ    <= 1'b0;
      unitsQ <= '0;
      cntQ   <= '0;
      morseQ <= 1'b0;
      doneQ  <= 1'b0;
      readyQ <= 1'b1;
    end else begin
      stateQ <= stateD;
      firstQ <= firstD;
      secQ   <= secD;
      selQ   <= selD;
      idxQ   <= idxD;
      lfQ    <= lfD;
      unitsQ <= unitsD;
      cntQ   <= cntD;
      morseQ <= morseD;
      doneQ  <= doneD;
      readyQ <= readyD;
    end
  end

  assign curSeq  = selQ ? secQ : firstQ;
  assign unitEnd = (cntQ == LastCnt);

  // Symbol at the current index; positions past the last pair read as empty.
  always_comb begin
    sym = 2'b11;
    case (idxQ)
      3'd0:    sym = curSeq[9:8];
      3'd1:    sym = curSeq[7:6];
      3'd2:    sym = curSeq[5:4];
      3'd3:    sym = curSeq[3:2];
      3'd4:    sym = curSeq[1:0];
      default: sym = 2'b11;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    stateD = stateQ;
    firstD = firstQ;
    secD   = secQ;
    selD   = selQ;
    idxD   = idxQ;
    lfD    = lfQ;
    unitsD = unitsQ;
    cntD   = cntQ;
    endSeq = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (SeqValid) begin
          firstD = FirstSeq;
          secD   = SecSeq;
          selD   = 1'b0;
          idxD   = '0;
          lfD    = 1'b0;
          cntD   = '0;
          stateD = StFetch;
        end
      end

      StFetch: begin
        cntD = '0;
        if (idxQ < 3'd5 && !sym[1]) begin
          stateD = StMark;
          unitsD = sym[0] ? 3'd3 : 3'd1;
          lfD    = 1'b1;
          idxD   = idxQ + 3'd1;
        end else if (idxQ < 3'd5 && sym == 2'b10) begin
          stateD = StGap;
          unitsD = 3'd4;
        end else if (lfQ) begin
          // Letter gap: the preceding element gap supplies the first unit of three.
          stateD = StGap;
          unitsD = 3'd2;
        end else begin
          endSeq = 1'b1;
        end
      end

      StMark, StElemGap, StGap: begin
        cntD = unitEnd ? '0 : cntQ + CNT_W'(1);
        if (unitEnd) begin
          if (unitsQ != 3'd1) begin
            unitsD = unitsQ - 3'd1;
          end else begin
            unique case (stateQ)
              StMark: begin
                stateD = StElemGap;
                unitsD = 3'd1;
              end
              StElemGap: stateD = StFetch;
              default:   endSeq = 1'b1;
            endcase
          end
        end
      end

      StDone: stateD = StIdle;

      default: stateD = StIdle;
    endcase

    if (endSeq) begin
      if (!selQ) begin
        selD   = 1'b1;
        idxD   = '0;
        lfD    = 1'b0;
        stateD = StFetch;
      end else begin
        stateD = StDone;
      end
    end
  end

  // Outputs are decoded from the next state and registered, so they track stateQ glitch-free.
  always_comb begin
    morseD = (stateD == StMark);
    doneD  = (stateD == StDone);
    readyD = (stateD == StIdle);
  end

  assign MorseOut = morseQ;
  assign Done     = doneQ;
  assign SeqReady = readyQ;
  assign Busy     = ~readyQ;

endmodule

// File: tb/tb_morse_sequence_player.sv
// Randomized and directed bench for morse_sequence_player against a per-cycle waveform model.
module tb_morse_sequence_player;

  localparam int U = 4;

  logic       Clk;
  logic       Resetbar;
  logic [9:0] FirstSeq;
  logic [9:0] SecSeq;
  logic       SeqValid;
  logic       SeqReady;
  logic       Busy;
  logic       MorseOut;
  logic       Done;

  int nVec;
  int nErr;
  bit expQ[$];

  morse_sequence_player #(
    .UNIT_CYCLES(U),
    .CNT_W      (3)
  ) dut (
    .Clk      (Clk),
    .Resetbar (Resetbar),
    .FirstSeq (FirstSeq),
    .SecSeq   (SecSeq),
    .SeqValid (SeqValid),
    .SeqReady (SeqReady),
    .Busy     (Busy),
    .MorseOut (MorseOut),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pushN(input bit v, input int n);
    repeat (n) expQ.push_back(v);
  endtask

  // Expected MorseOut for every cycle after the accept edge; the last entry is the Done cycle.
  task automatic buildExp(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] seqs[2];
    logic [9:0] t;
    logic [1:0] s;
    bit         lf;
    seqs[0] = a;
    seqs[1] = b;
    expQ.delete();
    for (int q = 0; q < 2; q++) begin
      lf = 0;
      pushN(0, 1);
      for (int i = 0; i <= 5; i++) begin
        t = seqs[q] << (2 * i);
        s = (i < 5) ? t[9:8] : 2'b11;
        if (s == 2'b00 || s == 2'b01) begin
          pushN(1, (s == 2'b00 ? 1 : 3) * U);
          pushN(0, U);
          pushN(0, 1);
          lf = 1;
        end else if (s == 2'b10) begin
          pushN(0, 4 * U);
          break;
        end else begin
          if (lf) pushN(0, 2 * U);
          break;
        end
      end
    end
    pushN(0, 1);
  endtask

  task automatic runPair(input logic [9:0] a, input logic [9:0] b, input bit abuse);
    int n;
    buildExp(a, b);
    n = expQ.size();
    @(negedge Clk);
    checkVal("readyPre", SeqReady, 1);
    FirstSeq = a;
    SecSeq   = b;
    SeqValid = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      if (abuse) begin
        SeqValid = 1'($urandom);
        FirstSeq = 10'($urandom);
        SecSeq   = 10'($urandom);
      end else begin
        SeqValid = 1'b0;
      end
      checkVal($sformatf("morse[%0d]", k), MorseOut, expQ[k]);
      checkVal($sformatf("done[%0d]", k), Done, (k == n - 1));
      checkVal($sformatf("busy[%0d]", k), Busy, 1);
    end
    @(negedge Clk);
    SeqValid = 1'b0;
    checkVal("readyPost", SeqReady, 1);
    checkVal("busyPost", Busy, 0);
    checkVal("donePost", Done, 0);
    checkVal("morsePost", MorseOut, 0);
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, ".morse"}, MorseOut, 0);
    checkVal({tag, ".ready"}, SeqReady, 1);
    checkVal({tag, ".busy"}, Busy, 0);
    checkVal({tag, ".done"}, Done, 0);
  endtask

  initial begin
    bit sawHigh;
    nVec     = 0;
    nErr     = 0;
    Resetbar = 1'b0;
    FirstSeq = '0;
    SecSeq   = '0;
    SeqValid = 1'b0;

    repeat (3) @(negedge Clk);
    checkIdle("rstHeld");
    Resetbar = 1'b1;
    repeat (2) @(negedge Clk);
    checkIdle("rstRel");

    runPair(10'b00_01_11_11_11, 10'b11_11_11_11_11, 0);
    runPair(10'b10_11_11_11_11, 10'b11_11_11_11_11, 0);
    runPair(10'b00_11_11_11_11, 10'b10_11_11_11_11, 0);
    runPair(10'b01_01_01_01_01, 10'b11_11_11_11_11, 0);
    runPair(10'b11_11_11_11_11, 10'b11_11_11_11_11, 0);

    // Mid-dash: a new pair is ignored, then reset aborts immediately.
    @(negedge Clk);
    FirstSeq = 10'b01_01_01_01_01;
    SecSeq   = 10'b01_01_01_01_01;
    SeqValid = 1'b1;
    @(negedge Clk);
    SeqValid = 1'b0;
    sawHigh  = 0;
    for (int k = 0; k < 20 && !sawHigh; k++) begin
      @(negedge Clk);
      sawHigh = MorseOut;
    end
    checkVal("dashSeen", sawHigh, 1);
    FirstSeq = 10'b10_10_10_10_10;
    SecSeq   = 10'b10_10_10_10_10;
    SeqValid = 1'b1;
    @(negedge Clk);
    checkVal("ignoreMorse", MorseOut, 1);
    checkVal("ignoreBusy", Busy, 1);
    @(negedge Clk);
    SeqValid = 1'b0;
    checkVal("ignoreMorse2", MorseOut, 1);
    #1 Resetbar = 1'b0;
    #1;
    checkIdle("abort");
    @(negedge Clk);
    checkIdle("abortHeld");
    Resetbar = 1'b1;
    @(negedge Clk);
    checkIdle("abortRel");
    runPair(10'b00_01_11_11_11, 10'b00_00_00_11_11, 0);

    for (int r = 0; r < 25; r++) begin
      runPair(10'($urandom), 10'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
